// File: rtl/to_ascii_num_if.sv
// Handshake and data bundle for the to_ascii_num formatter.
// The requester drives the master side; the formatter sits on the slave side.
interface to_ascii_num_if #(
    parameter int IN_WIDTH     = 64,
    parameter int OUTPUT_WIDTH = 24
);
    logic [IN_WIDTH-1:0]       VALUE;
    logic                      MODE;
    logic [7:0]                DIGITS_OUT;
    logic                      NOSEP;
    logic                      START;
    logic [OUTPUT_WIDTH*8-1:0] RESULT;
    logic                      IDLE;
    logic                      DONE;
    logic                      OVERFLOW;

    modport master (
        output VALUE, MODE, DIGITS_OUT, NOSEP, START,
        input  RESULT, IDLE, DONE, OVERFLOW
    );

    modport slave (
        input  VALUE, MODE, DIGITS_OUT, NOSEP, START,
        output RESULT, IDLE, DONE, OVERFLOW
    );
endinterface

// File: rtl/to_ascii_num.sv
// Unsigned value to right-justified ASCII text (hex or decimal).
// Decimal digits come from a serial double-dabble; digits are emitted one per cycle, LSD first.
module to_ascii_num #(
    parameter int IN_WIDTH     = 64,
    parameter int OUTPUT_WIDTH = 24,
    parameter int GROUP_HEX    = 4,
    parameter int GROUP_DEC    = 3,
    parameter int UPPER        = 0
) (
    input  logic          CLK,
    input  logic          RESETN,
    to_ascii_num_if.slave bus
);
    localparam int HEX_DIGITS = (IN_WIDTH + 3) / 4;
    localparam int DEC_DIGITS = ((IN_WIDTH * 1233) >> 12) + 1;
    localparam int SRC_DIGITS = (DEC_DIGITS > HEX_DIGITS) ? DEC_DIGITS : HEX_DIGITS;
    localparam int SRC_W      = SRC_DIGITS * 4;
    localparam int RES_W      = OUTPUT_WIDTH * 8;
    localparam int DST_W      = $clog2(OUTPUT_WIDTH + 3);
    localparam int BIT_W      = $clog2(IN_WIDTH);
    localparam logic [7:0] ALPHA = (UPPER != 0) ? 8'h41 : 8'h61;

    typedef enum logic [1:0] {S_IDLE, S_BCD, S_EMIT} state_t;

    state_t              state_reg, state_next;
    logic [SRC_W-1:0]    src_reg, src_next;
    logic [IN_WIDTH-1:0] val_reg, val_next;
    logic [BIT_W-1:0]    bit_cnt_reg, bit_cnt_next;
    logic [DST_W-1:0]    dst_reg, dst_next;
    logic [7:0]          count_reg, count_next;
    logic [7:0]          grp_reg, grp_next;
    logic [7:0]          n_reg, n_next;
    logic                auto_reg, auto_next;
    logic                mode_reg, mode_next;
    logic                nosep_reg, nosep_next;
    logic [RES_W-1:0]    result_reg, result_next;
    logic                done_reg, done_next;
    logic                ovf_reg, ovf_next;

    // Double-dabble correction applied to every BCD digit before the shift.
    logic [SRC_W-1:0] bcd_adj;
    for (genvar gi = 0; gi < SRC_DIGITS; gi++) begin : g_dabble
        assign bcd_adj[gi*4 +: 4] = (src_reg[gi*4 +: 4] >= 4'd5) ?
                                    src_reg[gi*4 +: 4] + 4'd3 : src_reg[gi*4 +: 4];
    end

    logic [7:0]       max_digits;
    logic [7:0]       grp_limit;
    logic [3:0]       digit;
    logic [7:0]       digit_char;
    logic [7:0]       sep_char;
    logic             sep_now;
    logic [DST_W-1:0] step;
    logic [DST_W-1:0] digit_pos;
    logic             fits;
    logic [SRC_W-1:0] src_rem;
    logic             last;

    assign max_digits = bus.MODE ? 8'(DEC_DIGITS) : 8'(HEX_DIGITS);
    assign grp_limit  = mode_reg ? 8'(GROUP_DEC) : 8'(GROUP_HEX);
    assign digit      = src_reg[3:0];
    assign digit_char = (digit < 4'd10) ? (8'h30 + {4'h0, digit})
                                        : (ALPHA + {4'h0, digit} - 8'd10);
    assign sep_char   = mode_reg ? 8'h2C : 8'h3A;
    assign sep_now    = (count_reg != 8'd0) && (grp_reg == 8'd0) && !nosep_reg;
    assign step       = sep_now ? DST_W'(2) : DST_W'(1);
    assign digit_pos  = sep_now ? dst_reg + DST_W'(1) : dst_reg;
    // A separator and its digit must both fit, otherwise nothing is written.
    assign fits       = (dst_reg + step) <= DST_W'(OUTPUT_WIDTH);
    assign src_rem    = src_reg >> 4;
    assign last       = auto_reg ? (src_rem == '0) : ((count_reg + 8'd1) == n_reg);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_reg   <= S_IDLE;
            src_reg     <= '0;
            val_reg     <= '0;
            bit_cnt_reg <= '0;
            dst_reg     <= '0;
            count_reg   <= '0;
            grp_reg     <= '0;
            n_reg       <= '0;
            auto_reg    <= 1'b0;
            mode_reg    <= 1'b0;
            nosep_reg   <= 1'b0;
            result_reg  <= '0;
            done_reg    <= 1'b0;
            ovf_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            src_reg     <= src_next;
            val_reg     <= val_next;
            bit_cnt_reg <= bit_cnt_next;
            dst_reg     <= dst_next;
            count_reg   <= count_next;
            grp_reg     <= grp_next;
            n_reg       <= n_next;
            auto_reg    <= auto_next;
            mode_reg    <= mode_next;
            nosep_reg   <= nosep_next;
            result_reg  <= result_next;
            done_reg    <= done_next;
            ovf_reg     <= ovf_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        src_next     = src_reg;
        val_next     = val_reg;
        bit_cnt_next = bit_cnt_reg;
        dst_next     = dst_reg;
        count_next   = count_reg;
        grp_next     = grp_reg;
        n_next       = n_reg;
        auto_next    = auto_reg;
        mode_next    = mode_reg;
        nosep_next   = nosep_reg;
        result_next  = result_reg;
        done_next    = 1'b0;
        ovf_next     = ovf_reg;

        case (state_reg)
            S_IDLE: begin
                if (bus.START) begin
                    result_next  = '0;
                    ovf_next     = 1'b0;
                    mode_next    = bus.MODE;
                    nosep_next   = bus.NOSEP;
                    auto_next    = (bus.DIGITS_OUT == 8'd0);
                    n_next       = (bus.DIGITS_OUT > max_digits) ? max_digits : bus.DIGITS_OUT;
                    dst_next     = '0;
                    count_next   = '0;
                    grp_next     = '0;
                    bit_cnt_next = '0;
                    if (bus.MODE) begin
                        src_next   = '0;
                        val_next   = bus.VALUE;
                        state_next = S_BCD;
                    end else begin
                        src_next   = SRC_W'(bus.VALUE);
                        state_next = S_EMIT;
                    end
                end
            end
            S_BCD: begin
                src_next     = (bcd_adj << 1) | SRC_W'(val_reg[IN_WIDTH-1]);
                val_next     = val_reg << 1;
                bit_cnt_next = bit_cnt_reg + BIT_W'(1);
                if (bit_cnt_reg == BIT_W'(IN_WIDTH - 1)) begin
                    state_next = S_EMIT;
                end
            end
            S_EMIT: begin
                if (!fits) begin
                    ovf_next   = 1'b1;
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                end else begin
                    for (int i = 0; i < OUTPUT_WIDTH; i++) begin
                        if (sep_now && (DST_W'(i) == dst_reg)) begin
                            result_next[i*8 +: 8] = sep_char;
                        end
                        if (DST_W'(i) == digit_pos) begin
                            result_next[i*8 +: 8] = digit_char;
                        end
                    end
                    dst_next   = dst_reg + step;
                    count_next = count_reg + 8'd1;
                    grp_next   = ((grp_reg + 8'd1) == grp_limit) ? 8'd0 : grp_reg + 8'd1;
                    src_next   = src_rem;
                    if (last) begin
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.RESULT   = result_reg;
    assign bus.IDLE     = (state_reg == S_IDLE) && !bus.START;
    assign bus.DONE     = done_reg;
    assign bus.OVERFLOW = ovf_reg;
endmodule

// File: tb/tb_to_ascii_num.sv
// Bench for to_ascii_num: vector table through a scoreboard, plus busy-start,
// start-on-DONE, asynchronous reset and a narrow upper-case instance.
module tb_to_ascii_num;
    localparam int OW  = 24;
    localparam int OW2 = 8;

    logic CLK    = 1'b0;
    logic RESETN = 1'b0;
    always #5 CLK = ~CLK;

    to_ascii_num_if #(.IN_WIDTH(64), .OUTPUT_WIDTH(OW))  bus();
    to_ascii_num_if #(.IN_WIDTH(16), .OUTPUT_WIDTH(OW2)) bus16();

    to_ascii_num #(.IN_WIDTH(64), .OUTPUT_WIDTH(OW), .GROUP_HEX(4), .GROUP_DEC(3), .UPPER(0))
        dut (.CLK(CLK), .RESETN(RESETN), .bus(bus));
    to_ascii_num #(.IN_WIDTH(16), .OUTPUT_WIDTH(OW2), .GROUP_HEX(4), .GROUP_DEC(3), .UPPER(1))
        dut16 (.CLK(CLK), .RESETN(RESETN), .bus(bus16));

    typedef struct {
        logic [63:0] value;
        logic        mode;
        logic [7:0]  digits;
        logic        nosep;
        string       exp_s;
        logic        exp_ovf;
        int          lat;
    } vec_t;

    typedef struct {
        logic [OW*8-1:0] res;
        logic            ovf;
        int              lat;
        int              start_cyc;
        string           name;
    } exp_t;

    exp_t sb_q[$];
    int   tests    = 0;
    int   fails    = 0;
    int   cyc      = 0;
    int   done_cnt = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [OW*8-1:0] to_res(input string s);
        logic [OW*8-1:0] r = '0;
        for (int i = 0; i < s.len(); i++) r[i*8 +: 8] = s[s.len()-1-i];
        return r;
    endfunction

    function automatic string to_str(input logic [OW*8-1:0] r);
        string s = "";
        for (int i = OW - 1; i >= 0; i--)
            if (r[i*8 +: 8] != 8'h00) s = $sformatf("%s%c", s, r[i*8 +: 8]);
        return s;
    endfunction

    function automatic vec_t mk(input logic [63:0] value, input logic mode, input logic [7:0] digits,
                                input logic nosep, input string exp_s, input logic exp_ovf, input int lat);
        vec_t v;
        v.value = value; v.mode = mode; v.digits = digits; v.nosep = nosep;
        v.exp_s = exp_s; v.exp_ovf = exp_ovf; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_res(input string name, input logic [OW*8-1:0] got, input logic [OW*8-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: RESULT \"%s\" (%h), expected \"%s\" (%h)",
                     name, to_str(got), got, to_str(exp), exp);
        end
    endtask

    // Scoreboard consumer: every DONE pulse must match the oldest pending conversion.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RESETN && bus.DONE) begin
                done_cnt++;
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: DONE with no pending conversion, RESULT \"%s\"",
                             to_str(bus.RESULT));
                end else begin
                    e = sb_q.pop_front();
                    chk_res({e.name, "_result"}, bus.RESULT, e.res);
                    chk({e.name, "_overflow"}, bus.OVERFLOW, e.ovf);
                    chk({e.name, "_latency"}, cyc - e.start_cyc, e.lat);
                    $display("[TB] %s: RESULT \"%s\" OVERFLOW=%0b latency=%0d",
                             e.name, to_str(bus.RESULT), bus.OVERFLOW, cyc - e.start_cyc);
                end
            end
        end
    end

    // Called just after a negedge; returns one negedge later with inputs scrambled.
    task automatic start_conv(input vec_t v, input string name);
        exp_t e;
        bus.VALUE      = v.value;
        bus.MODE       = v.mode;
        bus.DIGITS_OUT = v.digits;
        bus.NOSEP      = v.nosep;
        bus.START      = 1'b1;
        e.res = to_res(v.exp_s); e.ovf = v.exp_ovf; e.lat = v.lat;
        e.start_cyc = cyc + 1; e.name = name;
        sb_q.push_back(e);
        @(negedge CLK);
        bus.START      = 1'b0;
        bus.VALUE      = ~v.value;
        bus.MODE       = ~v.mode;
        bus.DIGITS_OUT = 8'd5;
        bus.NOSEP      = ~v.nosep;
    endtask

    task automatic wait_q_empty(input string name);
        for (int k = 0; k < 300; k++) begin
            if (sb_q.size() == 0) return;
            @(negedge CLK);
        end
        tests++;
        fails++;
        $display("FAIL %s_timeout: %0d conversions still pending, expected 0", name, sb_q.size());
        sb_q.delete();
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int ok = 0;
        for (int k = 0; k < 300 && ok == 0; k++) begin
            if (bus.IDLE) ok = 1;
            else @(negedge CLK);
        end
        chk({name, "_idle_before"}, ok, 1);
        start_conv(v, name);
        wait_q_empty(name);
        repeat (3) @(negedge CLK);
        chk_res({name, "_held"}, bus.RESULT, to_res(v.exp_s));
        chk({name, "_ovf_held"}, bus.OVERFLOW, v.exp_ovf);
    endtask

    task automatic run16(input logic [15:0] value, input logic mode, input logic [7:0] digits,
                         input logic nosep, input string exp_s, input int lat, input string name);
        logic [OW*8-1:0] er = to_res(exp_s);
        int start_c;
        int seen = 0;
        bus16.VALUE = value; bus16.MODE = mode; bus16.DIGITS_OUT = digits;
        bus16.NOSEP = nosep; bus16.START = 1'b1;
        start_c = cyc + 1;
        @(negedge CLK);
        bus16.START = 1'b0;
        bus16.VALUE = ~value;
        for (int k = 0; k < 100 && seen == 0; k++) begin
            if (bus16.DONE) seen = 1;
            else @(negedge CLK);
        end
        chk({name, "_done"}, seen, 1);
        tests++;
        if (bus16.RESULT !== er[OW2*8-1:0]) begin
            fails++;
            $display("FAIL %s_result: RESULT %h, expected %h (\"%s\")",
                     name, bus16.RESULT, er[OW2*8-1:0], exp_s);
        end
        chk({name, "_latency"}, cyc - start_c, lat);
        $display("[TB] %s: RESULT %h latency=%0d", name, bus16.RESULT, cyc - start_c);
        @(negedge CLK);
    endtask

    task automatic reset_mid(input vec_t v, input int k, input string name);
        int d0;
        start_conv(v, name);
        sb_q.delete();
        repeat (k) @(negedge CLK);
        if (v.mode == 1'b0) begin
            tests++;
            if (bus.RESULT == '0) begin
                fails++;
                $display("FAIL %s_partial: RESULT %h, expected nonzero partial text", name, bus.RESULT);
            end
        end
        #2 RESETN = 1'b0;
        #1;
        chk_res({name, "_result_cleared"}, bus.RESULT, '0);
        chk({name, "_done_low"}, bus.DONE, 0);
        chk({name, "_idle"}, bus.IDLE, 1);
        @(negedge CLK);
        RESETN = 1'b1;
        d0 = done_cnt;
        repeat (80) @(negedge CLK);
        chk({name, "_no_done"}, done_cnt - d0, 0);
        $display("[TB] %s: aborted by reset", name);
    endtask

    initial begin
        vec_t vecs[15];
        int   d0;
        int   found;
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[15];
        int   d0;
        int   found;

        vecs[0]  = mk(64'h1234, 1'b0, 8'd8, 1'b0, "0000:1234", 1'b0, 8);
        vecs[1]  = mk(64'd1234567, 1'b1, 8'd0, 1'b0, "1,234,567", 1'b0, 71);
        vecs[2]  = mk(64'd1234567, 1'b1, 8'd0, 1'b1, "1234567", 1'b0, 71);
        vecs[3]  = mk(64'd0, 1'b0, 8'd0, 1'b0, "0", 1'b0, 1);
        vecs[4]  = mk(64'd0, 1'b1, 8'd0, 1'b0, "0", 1'b0, 65);
        vecs[5]  = mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'd0, 1'b0, "446,744,073,709,551,615", 1'b1, 83);
        vecs[6]  = mk(64'hDEAD_BEEF, 1'b0, 8'd0, 1'b0, "dead:beef", 1'b0, 8);
        vecs[7]  = mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 8'd0, 1'b0, "ffff:ffff:ffff:ffff", 1'b0, 16);
        vecs[8]  = mk(64'hAB, 1'b0, 8'd200, 1'b1, "00000000000000ab", 1'b0, 16);
        vecs[9]  = mk(64'h1234_5678_9ABC_DEF0, 1'b0, 8'd0, 1'b1, "123456789abcdef0", 1'b0, 16);
        vecs[10] = mk(64'd42, 1'b1, 8'd5, 1'b0, "00,042", 1'b0, 69);
        vecs[11] = mk(64'd123456, 1'b1, 8'd3, 1'b0, "456", 1'b0, 67);
        vecs[12] = mk(64'd0, 1'b1, 8'd20, 1'b0, "000,000,000,000,000,000", 1'b1, 83);
        vecs[13] = mk(64'd1000, 1'b1, 8'd0, 1'b0, "1,000", 1'b0, 68);
        vecs[14] = mk(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'd20, 1'b1, "18446744073709551615", 1'b0, 84);

        bus.VALUE = '0; bus.MODE = 1'b0; bus.DIGITS_OUT = '0; bus.NOSEP = 1'b0; bus.START = 1'b0;
        bus16.VALUE = '0; bus16.MODE = 1'b0; bus16.DIGITS_OUT = '0; bus16.NOSEP = 1'b0; bus16.START = 1'b0;

        repeat (3) @(negedge CLK);
        chk_res("reset_result", bus.RESULT, '0);
        chk("reset_done", bus.DONE, 0);
        chk("reset_overflow", bus.OVERFLOW, 0);
        chk("reset_idle", bus.IDLE, 1);
        RESETN = 1'b1;
        @(negedge CLK);

        for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        run16(16'hBEEF, 1'b0, 8'd9, 1'b1, "BEEF", 4, "w16_clamp_upper");
        run16(16'hBEEF, 1'b0, 8'd0, 1'b0, "BEEF", 4, "w16_auto_hex");
        run16(16'd65535, 1'b1, 8'd0, 1'b0, "65,535", 21, "w16_dec_max");
        run16(16'h00A0, 1'b0, 8'd0, 1'b0, "A0", 2, "w16_auto_short");

        // START pulsed while busy must not disturb the running conversion.
        d0 = done_cnt;
        start_conv(vecs[1], "busy_first");
        repeat (10) @(negedge CLK);
        chk("busy_idle_low", bus.IDLE, 0);
        bus.VALUE = 64'd42; bus.MODE = 1'b0; bus.DIGITS_OUT = 8'd0; bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        wait_q_empty("busy_first");
        repeat (5) @(negedge CLK);
        chk("busy_single_done", done_cnt - d0, 1);

        // A START presented in the DONE cycle is accepted at that edge.
        start_conv(vecs[0], "done_cycle_a");
        found = 0;
        for (int k = 0; k < 50 && found == 0; k++) begin
            @(negedge CLK);
            if (bus.DONE) found = 1;
        end
        chk("done_cycle_seen", found, 1);
        start_conv(mk(64'd987654, 1'b1, 8'd0, 1'b0, "987,654", 1'b0, 70), "done_cycle_b");
        wait_q_empty("done_cycle_b");

        reset_mid(mk(64'h1234, 1'b0, 8'd16, 1'b1, "", 1'b0, 0), 6, "reset_emit");
        reset_mid(mk(64'd1234567, 1'b1, 8'd0, 1'b0, "", 1'b0, 0), 20, "reset_bcd");
        run_vec(vecs[1], "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
